alarm_bank: RTL

//  Multi-channel alarm unit for the digital clock; successor to the single-alarm comparator.

---
 rtl/alarm_bank.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/alarm_bank.sv
// Multi-channel BCD alarm unit: per-channel time storage edited by digit buttons,
// per-channel arming, match/edge detection, and a RING/SNOOZE state machine.
module alarm_bank #(
  parameter int N_ALARM    = 4,
  parameter int SEL_W      = 2,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic               clk_1,
  input  logic               rst_n,
  input  logic               sec_tick,
  input  logic [3:0]         cur_Hh,
  input  logic [3:0]         cur_Hl,
  input  logic [3:0]         cur_mh,
  input  logic [3:0]         cur_ml,
  input  logic [SEL_W-1:0]   sel,
  input  logic               btn_A,
  input  logic               btn_B,
  input  logic               btn_C,
  input  logic               btn_D,
  input  logic               btn_arm,
  input  logic               snooze,
  input  logic               stop,
  output logic [3:0]         Hh,
  output logic [3:0]         Hl,
  output logic [3:0]         Mh,
  output logic [3:0]         Ml,
  output logic [N_ALARM-1:0] armed,
  output logic               ring,
  output logic [SEL_W-1:0]   ring_ch
);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  localparam logic [SEL_W:0] N_LIMIT     = (SEL_W+1)'(N_ALARM);
  localparam logic [11:0]    RING_LAST   = 12'(RING_SEC - 1);
  localparam logic [11:0]    SNOOZE_LAST = 12'(SNOOZE_SEC - 1);

  logic [3:0] alarm_hh [N_ALARM];
  logic [3:0] alarm_hl [N_ALARM];
  logic [3:0] alarm_mh [N_ALARM];
  logic [3:0] alarm_ml [N_ALARM];

  logic [4:0] btn_now, btn_prev, btn_rise;
  logic       sel_valid;
  logic [3:0] next_hh, next_hl, next_mh, next_ml;

  logic [N_ALARM-1:0] match_now, match_r, match_d, trig;
  logic [SEL_W-1:0]   trig_idx;
  logic               ring_ch_armed;

  state_t           state_q, state_d;
  logic [11:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0] ring_ch_q, ring_ch_d;

  assign btn_now   = {btn_arm, btn_D, btn_C, btn_B, btn_A};
  assign btn_rise  = btn_now & ~btn_prev;
  assign sel_valid = ({1'b0, sel} < N_LIMIT);

  always_comb begin
    Hh = '0;
    Hl = '0;
    Mh = '0;
    Ml = '0;
    for (int i = 0; i < N_ALARM; i++) begin
      if (sel_valid && sel == SEL_W'(i)) begin
        Hh = alarm_hh[i];
        Hl = alarm_hl[i];
        Mh = alarm_mh[i];
        Ml = alarm_ml[i];
      end
    end
  end

  // Hours-units wrap depends on the already-updated hours-tens digit
  always_comb begin
    next_hh = Hh;
    if (btn_rise[0]) next_hh = (Hh >= 4'd2) ? 4'd0 : Hh + 4'd1;
    next_hl = Hl;
    if (btn_rise[1]) begin
      if (next_hh == 4'd2) next_hl = (Hl >= 4'd3) ? 4'd0 : Hl + 4'd1;
      else                 next_hl = (Hl >= 4'd9) ? 4'd0 : Hl + 4'd1;
    end else if (next_hh == 4'd2 && Hl > 4'd3) begin
      next_hl = 4'd0;
    end
    next_mh = Mh;
    if (btn_rise[2]) next_mh = (Mh >= 4'd5) ? 4'd0 : Mh + 4'd1;
    next_ml = Ml;
    if (btn_rise[3]) next_ml = (Ml >= 4'd9) ? 4'd0 : Ml + 4'd1;
  end

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev <= '0;
      armed    <= '0;
      for (int i = 0; i < N_ALARM; i++) begin
        alarm_hh[i] <= '0;
        alarm_hl[i] <= '0;
        alarm_mh[i] <= '0;
        alarm_ml[i] <= '0;
      end
    end else begin
      btn_prev <= btn_now;
      for (int i = 0; i < N_ALARM; i++) begin
        if (sel_valid && sel == SEL_W'(i)) begin
          alarm_hh[i] <= next_hh;
          alarm_hl[i] <= next_hl;
          alarm_mh[i] <= next_mh;
          alarm_ml[i] <= next_ml;
          armed[i]    <= armed[i] ^ btn_rise[4];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_ALARM; i++) begin
      match_now[i] = armed[i] &&
                     alarm_hh[i] == cur_Hh && alarm_hl[i] == cur_Hl &&
                     alarm_mh[i] == cur_mh && alarm_ml[i] == cur_ml;
    end
  end

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      match_r <= '0;
      match_d <= '0;
    end else begin
      match_r <= match_now;
      match_d <= match_r;
    end
  end

  assign trig = match_r & ~match_d;

  // Scan downwards so the lowest triggering channel wins
  always_comb begin
    trig_idx      = '0;
    ring_ch_armed = 1'b0;
    for (int i = N_ALARM - 1; i >= 0; i--) begin
      if (trig[i]) trig_idx = SEL_W'(i);
    end
    for (int i = 0; i < N_ALARM; i++) begin
      if (ring_ch_q == SEL_W'(i)) ring_ch_armed = armed[i];
    end
  end

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ring_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ring_ch_q <= ring_ch_d;
    end
  end

  // Triggers are only honoured in IDLE; stop outranks snooze and timeout
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ring_ch_d = ring_ch_q;
    unique case (state_q)
      IDLE: begin
        if (|trig) begin
          state_d   = RING;
          ring_ch_d = trig_idx;
          cnt_d     = '0;
        end
      end
      RING: begin
        if (!ring_ch_armed || stop) begin
          state_d = IDLE;
        end else if (sec_tick && cnt_q == RING_LAST) begin
          state_d = IDLE;
        end else if (snooze) begin
          state_d = SNOOZE;
          cnt_d   = '0;
        end else if (sec_tick) begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      SNOOZE: begin
        if (!ring_ch_armed || stop) begin
          state_d = IDLE;
        end else if (sec_tick && cnt_q == SNOOZE_LAST) begin
          state_d = RING;
          cnt_d   = '0;
        end else if (sec_tick) begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ring    = (state_q == RING);
  assign ring_ch = ring_ch_q;

endmodule
